// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flop, LSB first, start/busy/done handshake.
// Optional signed-overflow output is enabled by defining SERIAL_SUBTRACTOR_OVF_EN.

module serial_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_a, shift_b;
    logic [WIDTH-2:0] partial;
    logic             borrow_ff;
    logic [CW-1:0]    count;
    logic             cell_d, cell_bout;
    logic [WIDTH-1:0] partial_nxt;
    logic             last_bit, load;

    serial_sub_cell u_cell (
        .a    (shift_a[0]),
        .b    (shift_b[0]),
        .bin  (borrow_ff),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // partial keeps only the WIDTH-1 bits still needed; the full word exists only as partial_nxt
    assign partial_nxt = {cell_d, partial};
    assign last_bit    = (count == CW'(WIDTH - 1));
    assign load        = start && (state != SHIFT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_a   <= '0;
            shift_b   <= '0;
            partial   <= '0;
            borrow_ff <= 1'b0;
            count     <= '0;
            out       <= '0;
            borrow    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (load) begin
            shift_a   <= data_a;
            shift_b   <= data_b;
            partial   <= '0;
            borrow_ff <= 1'b0;
            count     <= '0;
        end else if (state == SHIFT) begin
            shift_a   <= shift_a >> 1;
            shift_b   <= shift_b >> 1;
            partial   <= partial_nxt[WIDTH-1:1];
            borrow_ff <= cell_bout;
            count     <= count + CW'(1);
            if (last_bit) begin
                out    <= partial_nxt;
                borrow <= cell_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                // on the last bit the cell inputs are the operand sign bits
                ovf    <= (shift_a[0] ^ shift_b[0]) & (shift_a[0] ^ cell_d);
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4); expected results queued at start, checked on done.
// Define SERIAL_SUBTRACTOR_OVF_EN to also check the overflow output.

module tb_serial_subtractor;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start = 1'b0;
    logic [W-1:0] data_a = '0, data_b = '0;
    logic         busy, done, borrow;
    logic [W-1:0] out;
    logic         ovf_obs;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
    assign ovf_obs = ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .data_a (data_a),
        .data_b (data_b),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .borrow (borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0, done_cnt = 0;
    logic [5:0] sb_q[$];
    int done_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected {ovf, borrow, out} from integer arithmetic
    function automatic logic [5:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb, sd, ud;
        logic o;
        ud = int'(a) - int'(b);
        sa = a[W-1] ? int'(a) - 16 : int'(a);
        sb = b[W-1] ? int'(b) - 16 : int'(b);
        sd = sa - sb;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        o = (sd > 7) || (sd < -8);
`else
        o = 1'b0;
`endif
        return {o, (ud < 0), W'(ud & 15)};
    endfunction

    always @(posedge clk) begin
        #1;
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            if (sb_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                logic [5:0] e;
                e = sb_q.pop_front();
                chk("out", 32'(out), 32'(e[3:0]));
                chk("borrow", 32'(borrow), 32'(e[4]));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                chk("ovf", 32'(ovf_obs), 32'(e[5]));
`endif
            end
        end
    end

    task automatic wait_done(input int target, input string tag);
        int i;
        for (i = 0; i < 20 && done_cnt < target; i++) @(negedge clk);
        chk(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int base;
        @(negedge clk);
        start = 1'b1; data_a = a; data_b = b;
        sb_q.push_back(model(a, b));
        base = done_cnt;
        @(negedge clk);
        start = 1'b0;
        wait_done(base + 1, "done_timeout");
    endtask

    initial begin
        int base, busy_n, first_done;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_ovf", 32'(ovf_obs), 32'd0);
        reset = 1'b1;

        // latency and busy window
        @(negedge clk);
        start = 1'b1; data_a = 4'b1101; data_b = 4'b0001;
        sb_q.push_back(model(4'b1101, 4'b0001));
        @(negedge clk);
        start = 1'b0;
        busy_n = 0; first_done = -1;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1 && first_done < 0) first_done = i;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(busy_n), 32'd4);
        chk("done_latency", 32'(first_done), 32'd4);
        chk("direct_out", 32'(out), 32'b1100);

        do_op(4'b0001, 4'b1101);
        do_op(4'b0000, 4'b0000);

        // back-to-back with start held high
        base = done_cnt;
        @(negedge clk);
        start = 1'b1; data_a = 4'b1101; data_b = 4'b0001;
        sb_q.push_back(model(4'b1101, 4'b0001));
        sb_q.push_back(model(4'b0101, 4'b0110));
        @(negedge clk);
        data_a = 4'b0101; data_b = 4'b0110;
        repeat (5) @(negedge clk);
        start = 1'b0;
        wait_done(base + 2, "b2b_timeout");
        if (done_cyc.size() >= 2)
            chk("b2b_spacing", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'd5);
        repeat (3) @(negedge clk);
        chk("b2b_count", 32'(done_cnt - base), 32'd2);

        // start and operand changes during SHIFT are ignored
        base = done_cnt;
        @(negedge clk);
        start = 1'b1; data_a = 4'b0110; data_b = 4'b0011;
        sb_q.push_back(model(4'b0110, 4'b0011));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; data_a = 4'b1111; data_b = 4'b0000;
        @(negedge clk);
        start = 1'b0; data_a = 4'b0000; data_b = 4'b1111;
        repeat (10) @(negedge clk);
        chk("ignore_count", 32'(done_cnt - base), 32'd1);

        // reset mid-operation aborts with no done
        base = done_cnt;
        @(negedge clk);
        start = 1'b1; data_a = 4'b1010; data_b = 4'b0011;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_out", 32'(out), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - base), 32'd0);
        do_op(4'b1010, 4'b0011);

        // signed overflow boundaries, then random operands
        do_op(4'b1000, 4'b0001);
        do_op(4'b0011, 4'b0001);
        do_op(4'b0111, 4'b1111);
        do_op(4'b1111, 4'b1111);
        for (int i = 0; i < 8; i++)
            do_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
